// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and helpers for the square-root core arbiter and its round-robin picker.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_SQRT_LATENCY = 9;
  localparam int DEF_CNT_W        = $clog2(DEF_SQRT_LATENCY + 1);

  // Wait-counter width able to hold a load value of latency-1.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

  function automatic int rr_next(input int idx, input int num_req);
    return (idx >= num_req - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Requester-side request/response handshake bundle; the arbiter sits on the slave modport.
interface sqrt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [OUT_W-1:0]        rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one fixed-latency square-root core among NUM_REQ requesters.
// Define SQRT_ARBITER_STATS_EN to add op_count, a saturating count of completed responses.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IN_W         = 8,
  parameter int OUT_W        = 8,
  parameter int SQRT_LATENCY = DEF_SQRT_LATENCY
) (
  input  logic             clk,
  input  logic             rst_,
  sqrt_arbiter_if.slave    bus,
  output logic             sq_start,
  output logic [IN_W-1:0]  sq_a,
  input  logic [OUT_W-1:0] sq_q,
  output logic             busy
`ifdef SQRT_ARBITER_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int            IDX_W    = $clog2(NUM_REQ);
  localparam int            CW       = cnt_width(SQRT_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SQRT_LATENCY - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               any_req;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [OUT_W-1:0]   rsp_data_q;
  logic               rsp_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // Accept is combinational so a requester that drops valid before the grant is never accepted.
  assign bus.req_ready = (state == IDLE && !rst_) ? arb_gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state != IDLE);
  assign rsp_done      = (state == RESP) && bus.rsp_ready[grant_idx];

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      cnt         <= '0;
      sq_a        <= '0;
      sq_start    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every decision below sees the pre-edge register values.
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= arb_idx;
            sq_a      <= bus.req_data[arb_idx*IN_W +: IN_W];
            sq_start  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          sq_start <= 1'b0;
          cnt      <= CNT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data_q             <= sq_q;
            rsp_valid_q            <= '0;
            rsp_valid_q[grant_idx] <= 1'b1;
            state                  <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid_q <= '0;
            rr_ptr      <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SQRT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      op_count <= '0;
    end else if (rsp_done && op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
